b11_arbiter: RTL and testbench

B11_ARBITER -- requirements
Module: b11_arbiter

---
 rtl/b11_arbiter.sv | 157 +++++++++++++++
 tb/tb_b11_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b11_arbiter.sv
// Three-requester round-robin front end for a shared scrambler datapath: grant, strobe, wait, respond.
// Optional build macro B11_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles without dp_done.
module b11_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [17:0] req_data,
  output logic [2:0]  req_ready,
  output logic [5:0]  dp_x_in,
  output logic        dp_stbi,
  input  logic        dp_done,
  input  logic [5:0]  dp_x_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  done_count
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_last;
  logic [5:0]  r_dp_x_in;
  logic [1:0]  r_rsp_id;
  logic [5:0]  r_rsp_data;
  logic [7:0]  r_done_count;
  logic        w_found;
  logic [1:0]  w_win;
  logic [5:0]  w_opnd;
  logic        w_accept;
  logic        w_timeout;

  if (TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_timeout
    $error("TIMEOUT must fit the 6-bit counter (1..63)");
  end

  // Search order starts just after the previous winner.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] v);
    logic [1:0] o0, o1, o2;
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (v[o0])      return {1'b1, o0};
    else if (v[o1]) return {1'b1, o1};
    else if (v[o2]) return {1'b1, o2};
    return 3'b000;
  endfunction

  assign {w_found, w_win} = rr_pick(r_last, req_valid);
  assign w_accept = (r_state == S_IDLE) && w_found && reset;

  always_comb begin
    case (w_win)
      2'd1:    w_opnd = req_data[11:6];
      2'd2:    w_opnd = req_data[17:12];
      default: w_opnd = req_data[5:0];
    endcase
  end

`ifdef B11_ARB_TIMEOUT_EN
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_inc;
  logic       r_rsp_err;

  assign w_cnt_inc = r_cnt + 6'd1;
  // A dp_done in the expiring cycle takes precedence over the abort.
  assign w_timeout = (r_state == S_WAIT) && !dp_done && (w_cnt_inc == 6'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt     <= 6'd0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)
        r_cnt <= 6'd0;
      else if (r_state == S_WAIT && !dp_done)
        r_cnt <= w_cnt_inc;
      if (r_state == S_WAIT && dp_done)
        r_rsp_err <= 1'b0;
      else if (w_timeout)
        r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (dp_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 3'b000;
    dp_stbi   = 1'b1;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (reset && w_found) req_ready = 3'b001 << w_win;
      end
      S_LAUNCH: dp_stbi   = 1'b0;
      S_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last       <= 2'd2;
      r_dp_x_in    <= 6'd0;
      r_rsp_id     <= 2'd0;
      r_rsp_data   <= 6'd0;
      r_done_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_dp_x_in <= w_opnd;
        r_rsp_id  <= w_win;
        r_last    <= w_win;
      end
      if (r_state == S_WAIT && dp_done)
        r_rsp_data <= dp_x_out;
      else if (w_timeout)
        r_rsp_data <= 6'd0;
      if (r_state == S_RESP && rsp_ready)
        r_done_count <= r_done_count + 8'd1;
    end
  end

  assign dp_x_in    = r_dp_x_in;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_b11_arbiter.sv
// Bench for b11_arbiter: vector table of transactions with a response scoreboard, plus
// hand sequences for stray dp_done, reset mid-WAIT and WAIT timeout / persistence.
module tb_b11_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [17:0] req_data = 18'd0;
  logic [2:0]  req_ready;
  logic [5:0]  dp_x_in;
  logic        dp_stbi;
  logic        dp_done = 1'b0;
  logic [5:0]  dp_x_out = 6'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  done_count;

  b11_arbiter #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_x_in(dp_x_in), .dp_stbi(dp_stbi), .dp_done(dp_done),
    .dp_x_out(dp_x_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .done_count(done_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] id;
    logic [5:0] data;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0]  v;
    logic [17:0] d;
    logic [1:0]  id;
    logic [5:0]  res;
    int          ddly;
    int          rdly;
    bit          launch_done;
  } vec_t;

  rsp_t       expq[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_dc = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Drive a request, check the grant, record the expected response and step into LAUNCH.
  task automatic grant(input logic [2:0] v, input logic [17:0] d, input logic [1:0] id,
                       input logic [5:0] data, input logic err);
    rsp_t e;
    req_valid = v;
    req_data  = d;
    #1;
    chk("req_ready_grant", req_ready, 3'b001 << id);
    e.id = id; e.data = data; e.err = err;
    expq.push_back(e);
    cyc();
    req_valid = 3'b000;
  endtask

  // Bounded wait for a response, compare against the scoreboard head, then handshake.
  task automatic rsp_handshake(input int exp_lat);
    rsp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    if (!rsp_valid || expq.size() == 0) begin
      chk("rsp_present", {31'd0, rsp_valid}, 1);
      return;
    end
    e = expq.pop_front();
    chk("rsp_id", rsp_id, e.id);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", rsp_err, e.err);
    rsp_ready = 1'b1;
    #1;
    chk("no_grant_in_resp_hs", req_ready, 0);
    cyc();
    rsp_ready = 1'b0;
    req_valid = 3'b000;
    exp_dc    = exp_dc + 8'd1;
    #1;
    chk("done_count", done_count, exp_dc);
    chk("idle_after_rsp", {busy, rsp_valid}, 2'b00);
  endtask

  task automatic run_txn(input vec_t t);
    rsp_t e;
    grant(t.v, t.d, t.id, t.res, 1'b0);
    if (t.launch_done) begin
      dp_done  = 1'b1;
      dp_x_out = 6'h3F;
    end
    #1;
    chk("stbi_launch", dp_stbi, 0);
    chk("dp_x_in", dp_x_in, t.d[6*t.id +: 6]);
    chk("busy_launch", busy, 1);
    cyc();
    dp_done = 1'b0;
    #1;
    chk("stbi_wait", dp_stbi, 1);
    for (int i = 0; i < t.ddly; i++) begin
      chk("no_rsp_in_wait", rsp_valid, 0);
      cyc();
    end
    dp_done  = 1'b1;
    dp_x_out = t.res;
    cyc();
    dp_done  = 1'b0;
    dp_x_out = 6'd0;
    if (t.rdly > 0 && rsp_valid && expq.size() > 0) begin
      e = expq[0];
      req_valid = t.v;
      #1;
      for (int i = 0; i < t.rdly; i++) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_id", rsp_id, e.id);
        chk("hold_data", rsp_data, e.data);
        chk("hold_ready0", req_ready, 0);
        chk("hold_count", done_count, exp_dc);
        cyc();
      end
    end
    rsp_handshake(0);
  endtask

  initial begin
    int   n;
    logic quiet;

    vecs[0] = '{3'b111, {6'd12, 6'd9, 6'd5},     2'd0, 6'h21, 1, 0, 1'b0};
    vecs[1] = '{3'b111, {6'd12, 6'd9, 6'd5},     2'd1, 6'h22, 1, 0, 1'b0};
    vecs[2] = '{3'b111, {6'd12, 6'd9, 6'd5},     2'd2, 6'h23, 1, 0, 1'b0};
    vecs[3] = '{3'b010, {6'h00, 6'h2A, 6'h00},   2'd1, 6'h11, 0, 5, 1'b0};
    vecs[4] = '{3'b101, {6'h15, 6'h33, 6'h07},   2'd2, 6'h3C, 2, 0, 1'b1};
    vecs[5] = '{3'b101, {6'h15, 6'h33, 6'h07},   2'd0, 6'h01, 0, 0, 1'b0};
    vecs[6] = '{3'b011, {6'h0F, 6'h1E, 6'h2D},   2'd1, 6'h2F, 1, 0, 1'b0};
    vecs[7] = '{3'b100, {6'h38, 6'h00, 6'h00},   2'd2, 6'h3E, 0, 2, 1'b0};

    // Reset with all requesters asserting.
    req_valid = 3'b111;
    req_data  = {6'd12, 6'd9, 6'd5};
    repeat (3) cyc();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stbi", dp_stbi, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_regs", {dp_x_in, rsp_id, rsp_data, rsp_err}, 0);
    chk("rst_done_count", done_count, 0);
    req_valid = 3'b000;
    reset     = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        dp_done  = 1'b1;
        dp_x_out = 6'h3F;
        cyc();
        dp_done  = 1'b0;
        #1;
        chk("idle_done_ignored", {busy, rsp_valid, req_ready}, 0);
        chk("idle_done_data", rsp_data, 6'h11);
        cyc();
      end
      run_txn(vecs[i]);
      if (i == 2) chk("done_count_three", done_count, 3);
    end

    // Reset in the middle of WAIT abandons the operation.
    grant(3'b010, {6'h00, 6'h19, 6'h00}, 2'd1, 6'h00, 1'b0);
    void'(expq.pop_back());
    cyc();
    cyc();
    reset     = 1'b0;
    req_valid = 3'b111;
    cyc();
    chk("midwait_rst_busy", busy, 0);
    chk("midwait_rst_stbi", dp_stbi, 1);
    chk("midwait_rst_valid", rsp_valid, 0);
    chk("midwait_rst_ready", req_ready, 0);
    chk("midwait_rst_count", done_count, 0);
    reset     = 1'b1;
    req_valid = 3'b000;
    exp_dc    = 8'd0;
    cyc();
    chk("post_rst_quiet", {busy, rsp_valid}, 0);
    run_txn('{3'b111, {6'h01, 6'h02, 6'h03}, 2'd0, 6'h2C, 1, 0, 1'b0});

`ifdef B11_ARB_TIMEOUT_EN
    grant(3'b001, {12'd0, 6'h0A}, 2'd0, 6'h00, 1'b1);
    cyc();
    n = 0;
    while (!rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("timeout_wait_cycles", n, 4);
    rsp_handshake(0);
    grant(3'b001, {12'd0, 6'h0B}, 2'd0, 6'h2B, 1'b0);
    cyc();
    repeat (3) cyc();
    dp_done  = 1'b1;
    dp_x_out = 6'h2B;
    cyc();
    dp_done  = 1'b0;
    rsp_handshake(0);
`else
    grant(3'b001, {12'd0, 6'h0A}, 2'd0, 6'h2B, 1'b0);
    cyc();
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid || !busy) quiet = 1'b0;
      cyc();
    end
    chk("wait_persists", quiet, 1);
    dp_done  = 1'b1;
    dp_x_out = 6'h2B;
    cyc();
    dp_done  = 1'b0;
    rsp_handshake(0);
`endif

    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
